// File: rtl/rcn_pkg.sv
// Shared ring definitions for the queued rcn master: bus field positions,
// the queued request record and the helper that turns a record into a ring word.
package rcn_pkg;

  localparam int RCN_W   = 67;
  localparam int VALID   = 66;
  localparam int PEND    = 65;
  localparam int WR      = 64;
  localparam int ID_HI   = 63;
  localparam int ID_LO   = 58;
  localparam int SEQ_HI  = 57;
  localparam int SEQ_LO  = 56;
  localparam int WE_HI   = 55;
  localparam int WE_LO   = 52;
  localparam int ADDR_HI = 51;
  localparam int ADDR_LO = 32;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  seq;
    logic [3:0]  mask;
    logic [19:0] addr;
    logic [31:0] data;
  } rcn_req_t;

  localparam int REQ_W = $bits(rcn_req_t);

  function automatic logic [RCN_W-1:0] rcn_pack_req(input rcn_req_t r, input logic [5:0] id);
    return {1'b1, 1'b1, r.wr, id, r.seq, r.mask, r.addr, r.data};
  endfunction

endpackage

// File: rtl/rcn_req_fifo.sv
// Synchronous show-ahead FIFO holding queued ring requests; the head entry is
// visible on rdata whenever the FIFO is not empty.
module rcn_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_s;
  logic             pop_s;

  // Extra pointer bit distinguishes full from empty when the indexes match.
  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s  = pop && !empty;
  assign push_s = push && (!full || pop_s);
  assign rdata  = mem_r[rd_ptr_r[AW-1:0]];

  // Read and write pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rcn_master_queued.sv
// Queued rcn ring master: buffers client requests, keeps up to MAX_OUT in flight
// with 2-bit sequence tags. Optional watchdog enabled by RCN_MASTER_TIMEOUT_EN.
module rcn_master_queued
  import rcn_pkg::*;
#(
  parameter logic [5:0] MASTER_ID      = 6'd0,
  parameter int         REQ_DEPTH      = 4,
  parameter int         MAX_OUT        = 4,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RCN_W-1:0] rcn_in,
  output logic [RCN_W-1:0] rcn_out,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [3:0]       req_mask,
  input  logic [21:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic [1:0]       req_seq,
  output logic [2:0]       outstanding,
  output logic             rsp_valid,
  output logic             rsp_wr,
  output logic [1:0]       rsp_seq,
  output logic [3:0]       rsp_mask,
  output logic [21:0]      rsp_addr,
  output logic [31:0]      rsp_data,
  output logic             timeout
);

  logic [RCN_W-1:0] rin_r;
  logic [RCN_W-1:0] rout_r;
  logic [1:0]       push_seq_r;
  logic [2:0]       outstanding_r;
  logic [2:0]       outstanding_next_s;
  logic             my_resp_s;
  logic             dec_s;
  logic             issue_s;
  logic             push_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             wdog_fire_s;
  logic [REQ_W-1:0] fifo_rdata_s;
  rcn_req_t         push_req_s;
  rcn_req_t         head_s;
  logic             unused_addr_s;

  assign my_resp_s = rin_r[VALID] && !rin_r[PEND] && (rin_r[ID_HI:ID_LO] == MASTER_ID);
  assign dec_s     = my_resp_s && (outstanding_r != 3'd0);

  // A slot freed by a response this cycle counts as available immediately.
  assign issue_s   = !fifo_empty_s
                  && ((outstanding_r - {2'b00, dec_s}) < 3'(MAX_OUT))
                  && (!rin_r[VALID] || my_resp_s);

  assign req_ready = !fifo_full_s || issue_s;
  assign push_s    = req_valid && req_ready;

  assign push_req_s    = '{wr: req_wr, seq: push_seq_r, mask: req_mask,
                           addr: req_addr[21:2], data: req_wdata};
  assign head_s        = rcn_req_t'(fifo_rdata_s);
  assign unused_addr_s = ^req_addr[1:0];

  rcn_req_fifo #(
    .DEPTH (REQ_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (issue_s),
    .wdata (push_req_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next in-flight count; a watchdog expiry drops every in-flight request
  always_comb begin
    outstanding_next_s = outstanding_r;
    if (wdog_fire_s) begin
      outstanding_next_s = {2'b00, issue_s};
    end else if (issue_s && !dec_s) begin
      outstanding_next_s = outstanding_r + 3'd1;
    end else if (!issue_s && dec_s) begin
      outstanding_next_s = outstanding_r - 3'd1;
    end else begin
      outstanding_next_s = outstanding_r;
    end
  end

  // Ring stage registers, push sequence counter and in-flight count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rin_r         <= '0;
      rout_r        <= '0;
      push_seq_r    <= 2'd0;
      outstanding_r <= 3'd0;
    end else begin
      rin_r <= rcn_in;
      if (issue_s) begin
        rout_r <= rcn_pack_req(head_s, MASTER_ID);
      end else if (my_resp_s) begin
        rout_r <= '0;
      end else begin
        rout_r <= rin_r;
      end
      if (push_s) push_seq_r <= push_seq_r + 2'd1;
      outstanding_r <= outstanding_next_s;
    end
  end

`ifdef RCN_MASTER_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WDOG_W-1:0] wdog_r;
  logic              timeout_r;

  assign wdog_fire_s = (outstanding_r != 3'd0) && !my_resp_s
                    && (wdog_r == WDOG_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: runs while waiting on responses, restarts on any response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_r    <= '0;
      timeout_r <= 1'b0;
    end else if (wdog_fire_s) begin
      wdog_r    <= '0;
      timeout_r <= 1'b1;
    end else if ((outstanding_r == 3'd0) || my_resp_s) begin
      wdog_r    <= '0;
      timeout_r <= 1'b0;
    end else begin
      wdog_r    <= wdog_r + WDOG_W'(1);
      timeout_r <= 1'b0;
    end
  end

  assign timeout = timeout_r;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
  assign wdog_fire_s      = 1'b0;
  assign timeout          = 1'b0;
`endif

  assign rcn_out     = rout_r;
  assign req_seq     = push_seq_r;
  assign outstanding = outstanding_r;

  assign rsp_valid = my_resp_s;
  assign rsp_wr    = rin_r[WR];
  assign rsp_seq   = rin_r[SEQ_HI:SEQ_LO];
  assign rsp_mask  = rin_r[WE_HI:WE_LO];
  assign rsp_addr  = {rin_r[ADDR_HI:ADDR_LO], 2'b00};
  assign rsp_data  = rin_r[DATA_HI:DATA_LO];

endmodule

// File: tb/tb_rcn_master_queued.sv
// Self-checking bench for rcn_master_queued (MASTER_ID=5, MAX_OUT=2, REQ_DEPTH=4).
// Issued requests are matched against a scoreboard filled when requests are pushed.
module tb_rcn_master_queued;

  localparam int W = 67;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] rcn_in;
  logic [W-1:0] rcn_out;
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [3:0]   req_mask;
  logic [21:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [1:0]   req_seq;
  logic [2:0]   outstanding;
  logic         rsp_valid;
  logic         rsp_wr;
  logic [1:0]   rsp_seq;
  logic [3:0]   rsp_mask;
  logic [21:0]  rsp_addr;
  logic [31:0]  rsp_data;
  logic         timeout;

  rcn_master_queued #(
    .MASTER_ID      (6'd5),
    .REQ_DEPTH      (4),
    .MAX_OUT        (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rcn_in      (rcn_in),
    .rcn_out     (rcn_out),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_mask    (req_mask),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_seq     (req_seq),
    .outstanding (outstanding),
    .rsp_valid   (rsp_valid),
    .rsp_wr      (rsp_wr),
    .rsp_seq     (rsp_seq),
    .rsp_mask    (rsp_mask),
    .rsp_addr    (rsp_addr),
    .rsp_data    (rsp_data),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb[$];
  logic [1:0]   seq_m;

  typedef struct {
    logic        wr;
    logic [3:0]  mask;
    logic [21:0] addr;
    logic [31:0] data;
    logic [1:0]  seq;
    logic [21:0] eaddr;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [W-1:0] mk_req(input logic wr, input logic [1:0] seq,
                                          input logic [3:0] mask, input logic [21:0] addr,
                                          input logic [31:0] data);
    return {1'b1, 1'b1, wr, 6'd5, seq, mask, addr[21:2], data};
  endfunction

  function automatic logic [W-1:0] mk_rsp(input logic [W-1:0] w);
    logic [W-1:0] r;
    r = w;
    r[65] = 1'b0;
    return r;
  endfunction

  function automatic logic [W-1:0] fw(input int k);
    return {3'b110, 6'd9, 2'd0, 4'h0, 20'h0, 32'hF00D0000 + 32'(k)};
  endfunction

  function automatic logic own_req(input logic [W-1:0] w);
    return w[66] && w[65] && (w[63:58] == 6'd5);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock; own requests seen on the ring are matched against the scoreboard
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    if (rst_n && own_req(rcn_out)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", rcn_out, '0);
      end else begin
        e = sb.pop_front();
        chk("sb_issue", rcn_out, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic wr, input logic [3:0] mask, input logic [21:0] addr,
                          input logic [31:0] data, output logic [W-1:0] w);
    req_valid = 1'b1;
    req_wr    = wr;
    req_mask  = mask;
    req_addr  = addr;
    req_wdata = data;
    chk("push_ready", W'(req_ready), W'(1'b1));
    chk("push_seq", W'(req_seq), W'(seq_m));
    w = mk_req(wr, seq_m, mask, addr, data);
    sb.push_back(w);
    seq_m = seq_m + 2'd1;
    tick();
    req_valid = 1'b0;
  endtask

  // Ring slave: answers every own request one cycle after it appears
  task automatic drain(input int n);
    for (int c = 0; c < n; c++) begin
      if (own_req(rcn_out)) rcn_in = mk_rsp(rcn_out);
      else                  rcn_in = '0;
      tick();
    end
    rcn_in = '0;
  endtask

  logic [W-1:0] w;
  logic [W-1:0] r;
  logic [W-1:0] w3[4];
  int           pulses;
  int           pulse_at;

  initial begin
    rst_n = 1'b0; rcn_in = '0; req_valid = 1'b0; req_wr = 1'b0;
    req_mask = 4'h0; req_addr = 22'h0; req_wdata = 32'h0; seq_m = 2'd0;

    tbl[0] = '{1'b0, 4'hF, 22'h3FFFFC, 32'h0,        2'd1, 22'h3FFFFC, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 4'h1, 22'h000007, 32'h12345678, 2'd2, 22'h000004, 32'h12345678};
    tbl[2] = '{1'b1, 4'hC, 22'h2AAAA8, 32'hFFFFFFFF, 2'd3, 22'h2AAAA8, 32'hFFFFFFFF};
    tbl[3] = '{1'b0, 4'h0, 22'h000000, 32'h0,        2'd0, 22'h000000, 32'h0BADF00D};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rcn_out", rcn_out, '0);
    chk("rst_req_ready", W'(req_ready), W'(1'b1));
    chk("rst_outstanding", W'(outstanding), W'(3'd0));
    chk("rst_req_seq", W'(req_seq), W'(2'd0));
    chk("rst_rsp_valid", W'(rsp_valid), W'(1'b0));
    chk("rst_timeout", W'(timeout), W'(1'b0));
    rst_n = 1'b1;
    tick();

    // Case 1: single write on an idle ring
    push_one(1'b1, 4'hF, 22'h100, 32'hA5A5A5A5, w);
    chk("t1_not_yet", rcn_out, '0);
    tick();
    chk("t1_req", rcn_out, {3'b111, 6'd5, 2'd0, 4'hF, 20'h00040, 32'hA5A5A5A5});
    chk("t1_outstanding", W'(outstanding), W'(3'd1));

    // Case 2: its response comes back
    rcn_in = mk_rsp(w);
    tick();
    rcn_in = '0;
    chk("t2_rsp_valid", W'(rsp_valid), W'(1'b1));
    chk("t2_rsp_wr", W'(rsp_wr), W'(1'b1));
    chk("t2_rsp_seq", W'(rsp_seq), W'(2'd0));
    chk("t2_rsp_addr", W'(rsp_addr), W'(22'h100));
    chk("t2_rsp_data", W'(rsp_data), W'(32'hA5A5A5A5));
    tick();
    chk("t2_rsp_pulse", W'(rsp_valid), W'(1'b0));
    chk("t2_rcn_out_cleared", rcn_out, '0);
    chk("t2_outstanding", W'(outstanding), W'(3'd0));

    // Table: request/response round trips
    for (int i = 0; i < 4; i++) begin
      push_one(tbl[i].wr, tbl[i].mask, tbl[i].addr, tbl[i].data, w);
      tick();
      chk($sformatf("tbl%0d_req", i), rcn_out,
          mk_req(tbl[i].wr, tbl[i].seq, tbl[i].mask, tbl[i].addr, tbl[i].data));
      r = mk_rsp(w);
      r[31:0] = tbl[i].rdata;
      rcn_in = r;
      tick();
      rcn_in = '0;
      chk($sformatf("tbl%0d_rsp_valid", i), W'(rsp_valid), W'(1'b1));
      chk($sformatf("tbl%0d_rsp_wr", i), W'(rsp_wr), W'(tbl[i].wr));
      chk($sformatf("tbl%0d_rsp_seq", i), W'(rsp_seq), W'(tbl[i].seq));
      chk($sformatf("tbl%0d_rsp_mask", i), W'(rsp_mask), W'(tbl[i].mask));
      chk($sformatf("tbl%0d_rsp_addr", i), W'(rsp_addr), W'(tbl[i].eaddr));
      chk($sformatf("tbl%0d_rsp_data", i), W'(rsp_data), W'(tbl[i].rdata));
      tick();
      chk($sformatf("tbl%0d_outstanding", i), W'(outstanding), W'(3'd0));
    end

    // Case 3: four reads, two in flight, slot reuse on response
    for (int i = 0; i < 4; i++) push_one(1'b0, 4'h3, 22'h200 + 22'(4 * i), 32'h0, w3[i]);
    tick();
    tick();
    chk("t3_outstanding_max", W'(outstanding), W'(3'd2));
    chk("t3_no_issue", rcn_out, '0);
    chk("t3_ready_half", W'(req_ready), W'(1'b1));
    rcn_in = mk_rsp(w3[0]);
    tick();
    rcn_in = '0;
    chk("t3_rsp_valid", W'(rsp_valid), W'(1'b1));
    chk("t3_rsp_seq", W'(rsp_seq), W'(2'd1));
    tick();
    chk("t3_slot_reuse", rcn_out, w3[2]);
    chk("t3_outstanding_reuse", W'(outstanding), W'(3'd2));
    drain(10);
    rcn_in = mk_rsp(w3[1]);
    tick();
    rcn_in = '0;
    tick();
    chk("t3_outstanding_done", W'(outstanding), W'(3'd0));

    // Case 4: foreign traffic passes through and blocks issue
    rcn_in = fw(0);
    push_one(1'b1, 4'hF, 22'h004, 32'hCAFE0001, w);
    for (int k = 1; k < 6; k++) begin
      rcn_in = fw(k);
      tick();
      chk($sformatf("t4_pass%0d", k), rcn_out, fw(k - 1));
      chk($sformatf("t4_blocked%0d", k), W'(outstanding), W'(3'd0));
    end
    rcn_in = '0;
    tick();
    chk("t4_pass_last", rcn_out, fw(5));
    tick();
    chk("t4_first_free", rcn_out, w);
    chk("t4_outstanding", W'(outstanding), W'(3'd1));
    drain(4);
    chk("t4_outstanding_done", W'(outstanding), W'(3'd0));

    // Case 5: fill the FIFO with the ring blocked
    for (int i = 0; i < 5; i++) begin
      rcn_in    = fw(10 + i);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_mask  = 4'hF;
      req_addr  = 22'h300 + 22'(4 * i);
      req_wdata = 32'h5000 + 32'(i);
      if (i < 4) begin
        chk($sformatf("t5_ready%0d", i), W'(req_ready), W'(1'b1));
        chk($sformatf("t5_seq%0d", i), W'(req_seq), W'(seq_m));
        sb.push_back(mk_req(1'b1, seq_m, 4'hF, req_addr, req_wdata));
        seq_m = seq_m + 2'd1;
      end else begin
        chk("t5_full_ready", W'(req_ready), W'(1'b0));
        chk("t5_full_seq", W'(req_seq), W'(seq_m));
      end
      tick();
    end
    req_valid = 1'b0;
    chk("t5_still_full", W'(req_ready), W'(1'b0));
    chk("t5_seq_held", W'(req_seq), W'(seq_m));
    drain(30);
    chk("t5_outstanding_done", W'(outstanding), W'(3'd0));
    chk("t5_ready_again", W'(req_ready), W'(1'b1));
    chk("t5_sb_empty", W'(sb.size()), W'(0));

    // Case 6: unanswered read and watchdog
    push_one(1'b0, 4'hF, 22'h010, 32'h0, w);
    tick();
    chk("t6_issue", rcn_out, w);
    pulses   = 0;
    pulse_at = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (timeout) begin
        pulses++;
        if (pulse_at < 0) pulse_at = c;
      end
    end
`ifdef RCN_MASTER_TIMEOUT_EN
    chk("t6_pulses", W'(pulses), W'(1));
    chk("t6_pulse_at", W'(pulse_at), W'(16));
    chk("t6_outstanding_cleared", W'(outstanding), W'(3'd0));
`else
    chk("t6_no_timeout", W'(pulses), W'(0));
    chk("t6_outstanding_held", W'(outstanding), W'(3'd1));
`endif
    rcn_in = mk_rsp(w);
    tick();
    rcn_in = '0;
    chk("t6_late_rsp_valid", W'(rsp_valid), W'(1'b1));
    tick();
    chk("t6_late_outstanding", W'(outstanding), W'(3'd0));
    rcn_in = mk_rsp(w);
    tick();
    rcn_in = '0;
    chk("t6_stray_rsp_valid", W'(rsp_valid), W'(1'b1));
    tick();
    chk("t6_stray_no_underflow", W'(outstanding), W'(3'd0));
    chk("final_sb_empty", W'(sb.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
